// File: rtl/vslc_pkg.sv
// Shared opcode constants, FSM state encoding and byte classification for the VSLC scan sequencer.
package vslc_pkg;

  localparam logic [7:0] OP_NOP_END = 8'hFF;
  localparam logic [3:0] SPARAM_HI  = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FETCH0,
    FETCH1,
    ISSUE0,
    ISSUE1,
    END,
    WAIT
  } state_e;

  function automatic logic is_sparam(input logic [7:0] b);
    return b[7:4] == SPARAM_HI;
  endfunction

endpackage

// File: rtl/vslc_scan_sequencer_if.sv
// Control, program-memory and executor signals of the scan sequencer.
// Memory reads hold mem_addr stable with mem_rd until mem_valid strobes.
interface vslc_scan_sequencer_if #(
  parameter int ADDR_W   = 8,
  parameter int PERIOD_W = 16
);
  logic                run;
  logic [ADDR_W-1:0]   prog_len;
  logic [PERIOD_W-1:0] scan_period;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_rd;
  logic [7:0]          mem_data;
  logic                mem_valid;
  logic [7:0]          ui_in;
  logic [7:0]          ui_snap;
  logic [7:0]          ui_prev;
  logic [7:0]          instr;
  logic                instr_ready;
  logic                scan_start;
  logic                scan_done;
  logic                busy;
  logic                overrun;
  logic                trunc_err;

  modport master (
    input  run, prog_len, scan_period, mem_data, mem_valid, ui_in,
    output mem_addr, mem_rd, ui_snap, ui_prev, instr, instr_ready,
           scan_start, scan_done, busy, overrun, trunc_err
  );

  modport slave (
    output run, prog_len, scan_period, mem_data, mem_valid, ui_in,
    input  mem_addr, mem_rd, ui_snap, ui_prev, instr, instr_ready,
           scan_start, scan_done, busy, overrun, trunc_err
  );
endinterface

// File: rtl/vslc_scan_timer.sv
// Scan period counter: reads 0 during START, then counts up and saturates at all-ones.
// expired_o is high once the period has elapsed, or always when the period is 0 (free-run).
module vslc_scan_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                expired_o
);

  localparam logic [PERIOD_W-1:0] ONE = 1;

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (period_i == '0) || (cnt_q >= (period_i - ONE));

endmodule

// File: rtl/vslc_scan_sequencer.sv
// Fetches program bytes and issues them to the executor once per scan, keeping sparam pairs adjacent.
// One fetch cycle per byte plus memory latency, one issue cycle per byte; memory stalls via mem_valid.
module vslc_scan_sequencer
  import vslc_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  vslc_scan_sequencer_if.master bus
);

  localparam logic [ADDR_W:0]   PC_ONE   = 1;
  localparam logic [ADDR_W:0]   PC_TWO   = 2;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_e          state_q, state_d;
  logic [ADDR_W:0] pc_q, pc_d;
  logic [7:0]      buf0_q, buf0_d, buf1_q, buf1_d;
  logic            pair_q, pair_d;
  logic [7:0]      snap_q, snap_d, prev_q, prev_d;
  logic            overrun_q, overrun_d, trunc_q, trunc_d;

  logic            mem_rd_c, instr_rdy_c, expired, timer_clr, in_scan;
  logic [7:0]      instr_c;
  logic [ADDR_W:0] len_ext;

  assign len_ext   = {1'b0, bus.prog_len};
  assign timer_clr = (state_d == START);
  assign in_scan   = state_q inside {FETCH0, FETCH1, ISSUE0, ISSUE1};

  vslc_scan_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clr),
    .period_i (bus.scan_period),
    .expired_o(expired)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    pair_d      = pair_q;
    snap_d      = snap_q;
    prev_d      = prev_q;
    overrun_d   = overrun_q;
    trunc_d     = trunc_q;
    mem_rd_c    = 1'b0;
    instr_c     = OP_NOP_END;
    instr_rdy_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = START;
        end else begin
          overrun_d = 1'b0;
          trunc_d   = 1'b0;
        end
      end
      START: begin
        prev_d  = snap_q;
        snap_d  = bus.ui_in;
        pc_d    = '0;
        pair_d  = 1'b0;
        state_d = (bus.prog_len == '0) ? END : FETCH0;
      end
      FETCH0: begin
        if (!bus.run) begin
          state_d = IDLE;
        end else begin
          mem_rd_c = 1'b1;
          if (bus.mem_valid) begin
            buf0_d = bus.mem_data;
            if (bus.mem_data == OP_NOP_END || pc_q == len_ext) begin
              state_d = END;
            end else if (is_sparam(bus.mem_data)) begin
              // A sparam with no room for its parameter byte is dropped, not issued alone.
              if (pc_q + PC_ONE == len_ext) begin
                trunc_d = 1'b1;
                state_d = END;
              end else begin
                pair_d  = 1'b1;
                state_d = FETCH1;
              end
            end else begin
              state_d = ISSUE0;
            end
          end
        end
      end
      FETCH1: begin
        mem_rd_c = 1'b1;
        if (bus.mem_valid) begin
          buf1_d  = bus.mem_data;
          state_d = ISSUE0;
        end
      end
      ISSUE0: begin
        instr_c     = buf0_q;
        instr_rdy_c = 1'b1;
        if (pair_q) begin
          state_d = ISSUE1;
        end else begin
          pc_d    = pc_q + PC_ONE;
          state_d = bus.run ? FETCH0 : IDLE;
        end
      end
      ISSUE1: begin
        instr_c     = buf1_q;
        instr_rdy_c = 1'b1;
        pair_d      = 1'b0;
        pc_d        = pc_q + PC_TWO;
        state_d     = bus.run ? FETCH0 : IDLE;
      end
      END, WAIT: begin
        if (!bus.run) begin
          state_d = IDLE;
        end else if (expired) begin
          state_d = START;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (in_scan && bus.scan_period != '0 && expired) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      buf0_q    <= OP_NOP_END;
      buf1_q    <= OP_NOP_END;
      pair_q    <= 1'b0;
      snap_q    <= '0;
      prev_q    <= '0;
      overrun_q <= 1'b0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      pair_q    <= pair_d;
      snap_q    <= snap_d;
      prev_q    <= prev_d;
      overrun_q <= overrun_d;
      trunc_q   <= trunc_d;
    end
  end

  assign bus.mem_addr    = pc_q[ADDR_W-1:0] + ((state_q == FETCH1) ? ADDR_ONE : '0);
  assign bus.mem_rd      = mem_rd_c;
  assign bus.instr       = instr_c;
  assign bus.instr_ready = instr_rdy_c;
  assign bus.ui_snap     = snap_q;
  assign bus.ui_prev     = prev_q;
  assign bus.scan_start  = (state_q == START);
  assign bus.scan_done   = (state_q == END);
  assign bus.busy        = (state_q != IDLE);
  assign bus.overrun     = overrun_q;
  assign bus.trunc_err   = trunc_q;

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Bench for vslc_scan_sequencer: random programs against a program-walk reference model,
// plus directed cases for run drop mid-pair and asynchronous reset mid-issue.
module tb_vslc_scan_sequencer;

  localparam int ADDR_W   = 8;
  localparam int PERIOD_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vslc_scan_sequencer_if #(.ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W)) sif ();

  vslc_scan_sequencer #(.ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  // Program memory with fixed per-test latency; a dropped mem_rd restarts the wait.
  logic [7:0] mem [0:255];
  int lat   = 0;
  int waitc = 0;

  always_comb begin
    sif.mem_valid = sif.mem_rd && (waitc == lat);
    sif.mem_data  = sif.mem_valid ? mem[sif.mem_addr] : 8'h00;
  end

  always @(posedge clk) begin
    if (!sif.mem_rd || sif.mem_valid) waitc <= 0;
    else                              waitc <= waitc + 1;
  end

  initial begin
    sif.ui_in = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      sif.ui_in = 8'($urandom);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model of one scan, derived from the program bytes.
  logic [7:0] exp_b[$];
  bit         exp_second[$];
  int         exp_E, exp_int;
  bit         exp_trunc, exp_over;
  bit         st_trunc, st_over;

  logic [7:0] obs_b[$];
  int         obs_c[$];
  int         cyc, start_cyc, done_cnt;
  bit         have_prev;
  logic [7:0] snap_exp, prev_exp;

  function automatic void build_model(input int len, input int period);
    int         pc, reads;
    bit         fin;
    logic [7:0] b;
    exp_b.delete();
    exp_second.delete();
    exp_trunc = 1'b0;
    pc = 0;
    reads = 0;
    fin = (len == 0);
    while (!fin) begin
      reads++;
      b = mem[pc];
      if (b == 8'hFF || pc == len) begin
        fin = 1'b1;
      end else if (b[7:4] == 4'hA) begin
        if (pc + 1 == len) begin
          exp_trunc = 1'b1;
          fin = 1'b1;
        end else begin
          reads++;
          exp_b.push_back(b);
          exp_second.push_back(1'b0);
          exp_b.push_back(mem[pc+1]);
          exp_second.push_back(1'b1);
          pc += 2;
        end
      end else begin
        exp_b.push_back(b);
        exp_second.push_back(1'b0);
        pc++;
      end
    end
    exp_E    = 1 + reads * (lat + 1) + exp_b.size();
    exp_over = (period != 0) && (exp_E >= period) && (len != 0);
    exp_int  = (period == 0 || exp_E + 1 > period) ? exp_E + 1 : period;
  endfunction

  task automatic sample_cycle();
    cyc++;
    if (!sif.instr_ready) check_eq("instr_idle_ff", sif.instr, 8'hFF);
    if (sif.scan_start) begin
      if (have_prev) check_eq("start_gap", cyc - start_cyc, exp_int);
      have_prev = 1'b1;
      start_cyc = cyc;
      obs_b.delete();
      obs_c.delete();
      prev_exp = snap_exp;
      snap_exp = sif.ui_in;
    end
    if (sif.instr_ready) begin
      obs_b.push_back(sif.instr);
      obs_c.push_back(cyc);
    end
    if (sif.scan_done) begin
      check_eq("done_offset", cyc - start_cyc, exp_E);
      check_eq("n_issued", obs_b.size(), exp_b.size());
      for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
        check_eq("instr_byte", obs_b[i], exp_b[i]);
        if (exp_second[i] && i > 0) check_eq("pair_gap", obs_c[i] - obs_c[i-1], 1);
      end
      st_trunc |= exp_trunc;
      st_over  |= exp_over;
      check_eq("trunc_err", sif.trunc_err, st_trunc);
      check_eq("overrun", sif.overrun, st_over);
      check_eq("ui_snap", sif.ui_snap, snap_exp);
      check_eq("ui_prev", sif.ui_prev, prev_exp);
      done_cnt++;
    end
  endtask

  task automatic stop_and_clear();
    sif.run = 1'b0;
    for (int k = 0; k < 200 && sif.busy; k++) begin
      @(negedge clk);
      sample_cycle();
    end
    check_eq("went_idle", sif.busy, 0);
    @(negedge clk);
    sample_cycle();
    check_eq("sticky_clr_over", sif.overrun, 0);
    check_eq("sticky_clr_trunc", sif.trunc_err, 0);
    st_over   = 1'b0;
    st_trunc  = 1'b0;
    have_prev = 1'b0;
  endtask

  task automatic run_test(input int len, input int period, input int l, input int nscans);
    sif.prog_len    = 8'(len);
    sif.scan_period = 16'(period);
    lat             = l;
    build_model(len, period);
    have_prev = 1'b0;
    done_cnt  = 0;
    sif.run   = 1'b1;
    for (int k = 0; k < 6000 && done_cnt < nscans; k++) begin
      @(negedge clk);
      sample_cycle();
    end
    check_eq("scans_completed", done_cnt, nscans);
    stop_and_clear();
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    int r, len, per;
    rst             = 1'b1;
    sif.run         = 1'b0;
    sif.prog_len    = '0;
    sif.scan_period = '0;
    cyc = 0; start_cyc = 0; done_cnt = 0; have_prev = 1'b0;
    snap_exp = 8'h00; prev_exp = 8'h00; st_trunc = 1'b0; st_over = 1'b0;
    fill_random();
    repeat (3) @(negedge clk);
    check_eq("rst_instr", sif.instr, 8'hFF);
    check_eq("rst_instr_ready", sif.instr_ready, 0);
    check_eq("rst_mem_rd", sif.mem_rd, 0);
    check_eq("rst_mem_addr", sif.mem_addr, 0);
    check_eq("rst_busy", sif.busy, 0);
    check_eq("rst_flags", {sif.overrun, sif.trunc_err, sif.scan_start, sif.scan_done}, 0);
    check_eq("rst_ui", {sif.ui_snap, sif.ui_prev}, 0);
    rst = 1'b0;
    @(negedge clk);

    mem[0] = 8'h00; mem[1] = 8'h80; mem[2] = 8'hFF;
    run_test(3, 0, 0, 3);
    mem[0] = 8'hA9; mem[1] = 8'h17; mem[2] = 8'h40;
    run_test(3, 0, 3, 2);
    mem[0] = 8'hA2;
    run_test(1, 0, 0, 2);
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    run_test(3, 20, 0, 3);
    for (int i = 0; i < 6; i++) mem[i] = 8'(8'h10 * (i + 1));
    run_test(6, 4, 2, 3);
    run_test(0, 0, 1, 3);
    run_test(0, 5, 0, 2);

    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 256; i++) begin
        r = $urandom_range(0, 19);
        if (r < 4)       mem[i] = {4'hA, 4'($urandom)};
        else if (r == 4) mem[i] = 8'hFF;
        else             mem[i] = 8'($urandom);
      end
      len = $urandom_range(0, 14);
      per = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 80);
      run_test(len, per, $urandom_range(0, 3), 3);
    end

    // Dropping run while the parameter byte is in flight must still issue the whole pair.
    mem[0] = 8'hA5; mem[1] = 8'h33; mem[2] = 8'h44; mem[3] = 8'hFF;
    sif.prog_len = 8'd4; sif.scan_period = '0; lat = 5;
    build_model(4, 0);
    have_prev = 1'b0;
    sif.run   = 1'b1;
    for (int k = 0; k < 200 && !(sif.mem_rd && sif.mem_addr == 8'd1); k++) begin
      @(negedge clk);
      sample_cycle();
    end
    check_eq("fetch1_reached", int'(sif.mem_rd && sif.mem_addr == 8'd1), 1);
    sif.run = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      sample_cycle();
    end
    check_eq("drop_n_issued", obs_b.size(), 2);
    if (obs_b.size() >= 2) begin
      check_eq("drop_byte0", obs_b[0], 8'hA5);
      check_eq("drop_byte1", obs_b[1], 8'h33);
      check_eq("drop_pair_gap", obs_c[1] - obs_c[0], 1);
    end
    check_eq("drop_idle", sif.busy, 0);
    stop_and_clear();

    // Asynchronous reset in the middle of an issue cycle.
    mem[0] = 8'h00; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'hFF;
    sif.prog_len = 8'd4; lat = 0;
    build_model(4, 0);
    sif.run = 1'b1;
    for (int k = 0; k < 100 && !sif.instr_ready; k++) begin
      @(negedge clk);
      sample_cycle();
    end
    check_eq("issue_seen", sif.instr_ready, 1);
    rst = 1'b1;
    #1;
    check_eq("arst_instr", sif.instr, 8'hFF);
    check_eq("arst_instr_ready", sif.instr_ready, 0);
    check_eq("arst_busy", sif.busy, 0);
    check_eq("arst_mem_rd", sif.mem_rd, 0);
    sif.run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    snap_exp = 8'h00; prev_exp = 8'h00; have_prev = 1'b0;
    st_over = 1'b0; st_trunc = 1'b0;
    @(negedge clk);
    check_eq("arst_ui", {sif.ui_snap, sif.ui_prev}, 0);
    run_test(4, 0, 0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
